row_selector: RTL and testbench

- Responder side of the motion controller's row scan handshake (startSelector / selectorComplete) in the cartridge reader.
- On a start pulse it steps a column multiplexer across every nit of the current row and samples the digital sensor bit for each column.
- Each column gets a settle wait, then a 3-sample majority vote; the assembled row word is presented with a one-cycle valid/complete pulse.
- Sits between the motion controller and the sensor mux/illumination hardware; feeds row words to downstream data assembly.

---
 rtl/row_selector.sv | 155 +++++++++++++++
 tb/tb_row_selector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/row_selector.sv
// Row scan responder: walks the column mux across one row, settles, votes
// three synchronized sensor samples per column and publishes the row word.
module row_selector #(
    parameter int unsigned NUM_COLUMNS   = 8,
    parameter int unsigned SEL_WIDTH     = 3,
    parameter int unsigned SETTLE_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startSelector,
    input  logic                   sensorBit,
    output logic [SEL_WIDTH-1:0]   columnSelect,
    output logic                   sensorEnable,
    output logic                   busy,
    output logic [NUM_COLUMNS-1:0] rowData,
    output logic                   rowValid,
    output logic                   selectorComplete
);

    localparam int unsigned CNT_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SEL_WIDTH-1:0] LAST_COL    = SEL_WIDTH'(NUM_COLUMNS - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_SETTLE = CNT_WIDTH'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SAMPLE = 3'd2,
        STORE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   column_q, column_d;
    logic [CNT_WIDTH-1:0]   settle_q, settle_d;
    logic [1:0]             idx_q, idx_d;
    logic [2:0]             samples_q, samples_d;
    logic [NUM_COLUMNS-1:0] shadow_q, shadow_d;
    logic [NUM_COLUMNS-1:0] row_d;
    logic [1:0]             sync_q;
    logic                   vote;
    logic                   scanning_d;
    logic                   busy_d;
    logic                   done_d;
    logic [SEL_WIDTH-1:0]   column_sel_d;

    // Two-flop synchronizer for the asynchronous sensor output
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sensorBit};
        end
    end

    assign vote = (samples_q[0] & samples_q[1]) |
                  (samples_q[0] & samples_q[2]) |
                  (samples_q[1] & samples_q[2]);

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d      = state_q;
        column_d     = column_q;
        settle_d     = settle_q;
        idx_d        = idx_q;
        samples_d    = samples_q;
        shadow_d     = shadow_q;
        row_d        = rowData;

        unique case (state_q)
            IDLE: begin
                if (startSelector) begin
                    state_d  = SELECT;
                    column_d = '0;
                    settle_d = '0;
                    shadow_d = '0;
                end
            end
            SELECT: begin
                if (settle_q == LAST_SETTLE) begin
                    state_d = SAMPLE;
                    idx_d   = 2'd0;
                end else begin
                    settle_d = settle_q + CNT_WIDTH'(1);
                end
            end
            SAMPLE: begin
                case (idx_q)
                    2'd0:    samples_d[0] = sync_q[1];
                    2'd1:    samples_d[1] = sync_q[1];
                    default: samples_d[2] = sync_q[1];
                endcase
                if (idx_q == 2'd2) begin
                    state_d = STORE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            STORE: begin
                shadow_d[column_q] = vote;
                if (column_q == LAST_COL) begin
                    state_d = DONE;
                    // Publish together with the final column so rowData is valid with rowValid
                    row_d   = shadow_d;
                end else begin
                    state_d  = SELECT;
                    column_d = column_q + SEL_WIDTH'(1);
                    settle_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        scanning_d   = (state_d == SELECT) || (state_d == SAMPLE) || (state_d == STORE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        column_sel_d = scanning_d ? column_d : '0;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            column_q         <= '0;
            settle_q         <= '0;
            idx_q            <= '0;
            samples_q        <= '0;
            shadow_q         <= '0;
            rowData          <= '0;
            columnSelect     <= '0;
            sensorEnable     <= 1'b0;
            busy             <= 1'b0;
            rowValid         <= 1'b0;
            selectorComplete <= 1'b0;
        end else begin
            state_q          <= state_d;
            column_q         <= column_d;
            settle_q         <= settle_d;
            idx_q            <= idx_d;
            samples_q        <= samples_d;
            shadow_q         <= shadow_d;
            rowData          <= row_d;
            columnSelect     <= column_sel_d;
            sensorEnable     <= scanning_d;
            busy             <= busy_d;
            rowValid         <= done_d;
            selectorComplete <= done_d;
        end
    end

endmodule

// File: tb/tb_row_selector.sv
// Self-checking bench for row_selector with a short settle time.
module tb_row_selector;

    localparam int unsigned NC   = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned SC   = 4;
    localparam int unsigned PER  = SC + 4;
    localparam int unsigned LAST = NC * PER + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          startSelector;
    logic          sensorBit;
    logic [SW-1:0] columnSelect;
    logic          sensorEnable;
    logic          busy;
    logic [NC-1:0] rowData;
    logic          rowValid;
    logic          selectorComplete;

    row_selector #(
        .NUM_COLUMNS  (NC),
        .SEL_WIDTH    (SW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startSelector   (startSelector),
        .sensorBit       (sensorBit),
        .columnSelect    (columnSelect),
        .sensorEnable    (sensorEnable),
        .busy            (busy),
        .rowData         (rowData),
        .rowValid        (rowValid),
        .selectorComplete(selectorComplete)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [NC-1:0] prev_row;
    logic          wave [0:LAST];

    typedef struct {
        logic [NC-1:0] pattern;
        int            glitch_col;
        logic [2:0]    glitch_mask;
        bit            extra_starts;
        logic [NC-1:0] exp_row;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Sensor value sampled as vote n of column k was driven two cycles before
    // the n-th SAMPLE cycle, which falls SC cycles after the column's SELECT entry.
    function automatic logic [NC-1:0] model_row();
        logic [NC-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NC); k++) begin
            int ones;
            ones = 0;
            for (int n = 0; n < 3; n++) begin
                ones += int'(wave[k * int'(PER) + int'(SC) - 1 + n]);
            end
            r[k] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic build_wave(input logic [NC-1:0] pattern, input int gcol, input logic [2:0] gmask);
        for (int c = 0; c <= int'(LAST); c++) begin
            int k;
            k = c / int'(PER);
            if (k > int'(NC) - 1) k = int'(NC) - 1;
            wave[c] = pattern[k];
        end
        if (gcol >= 0) begin
            for (int n = 0; n < 3; n++) begin
                if (gmask[n]) wave[gcol * int'(PER) + int'(SC) - 1 + n] = ~pattern[gcol];
            end
        end
    endtask

    task automatic random_wave();
        for (int c = 0; c <= int'(LAST); c++) wave[c] = 1'($urandom_range(0, 1));
    endtask

    // One full scan from the start cycle through the complete cycle, checked every cycle
    task automatic run_scan(input bit extra);
        logic [NC-1:0] row;
        row = model_row();
        for (int c = 0; c <= int'(LAST); c++) begin
            bit act;
            int col;
            act = (c >= 1) && (c < int'(LAST));
            col = act ? (c - 1) / int'(PER) : 0;
            check("busy",              c, int'(busy),             int'(c >= 1));
            check("sensor_enable",     c, int'(sensorEnable),     int'(act));
            check("column_select",     c, int'(columnSelect),     col);
            check("row_valid",         c, int'(rowValid),         int'(c == int'(LAST)));
            check("selector_complete", c, int'(selectorComplete), int'(c == int'(LAST)));
            check("row_data",          c, int'(rowData),          int'((c == int'(LAST)) ? row : prev_row));
            startSelector = (c == 0) || (extra && (c == 10 || c == 30));
            sensorBit     = wave[c];
            @(posedge clk);
            #1;
        end
        startSelector = 1'b0;
        prev_row      = row;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, -1, 3'b000, 1'b0, 8'hA5};
        vecs[1] = '{8'h08,  3, 3'b010, 1'b0, 8'h08};
        vecs[2] = '{8'h08,  3, 3'b011, 1'b0, 8'h00};
        vecs[3] = '{8'hA5, -1, 3'b000, 1'b1, 8'hA5};
        vecs[4] = '{8'hFF,  0, 3'b101, 1'b0, 8'hFE};
        vecs[5] = '{8'h80,  7, 3'b100, 1'b0, 8'h80};

        reset         = 1'b1;
        startSelector = 1'b0;
        sensorBit     = 1'b0;
        prev_row      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: everything quiet
        for (int c = 0; c < 20; c++) begin
            check("idle_busy",     c, int'(busy),             0);
            check("idle_enable",   c, int'(sensorEnable),     0);
            check("idle_column",   c, int'(columnSelect),     0);
            check("idle_row",      c, int'(rowData),          0);
            check("idle_valid",    c, int'(rowValid),         0);
            check("idle_complete", c, int'(selectorComplete), 0);
            @(posedge clk);
            #1;
        end

        // Directed table: patterns, vote corners, ignored extra starts
        for (int i = 0; i < 6; i++) begin
            build_wave(vecs[i].pattern, vecs[i].glitch_col, vecs[i].glitch_mask);
            run_scan(vecs[i].extra_starts);
            check("table_row", i, int'(rowData), int'(vecs[i].exp_row));
        end

        // Reset in the middle of a scan aborts it without a complete pulse
        random_wave();
        for (int c = 0; c <= 20; c++) begin
            check("abort_busy_pre", c, int'(busy), int'(c >= 1));
            startSelector = (c == 0);
            sensorBit     = wave[c];
            reset         = (c == 20);
            @(posedge clk);
            #1;
        end
        reset         = 1'b0;
        startSelector = 1'b0;
        check("abort_enable", 21, int'(sensorEnable), 0);
        check("abort_row",    21, int'(rowData),      0);
        check("abort_column", 21, int'(columnSelect), 0);
        check("abort_valid",  21, int'(rowValid),     0);
        prev_row = '0;
        for (int c = 21; c < 91; c++) begin
            check("abort_busy",        c, int'(busy),             0);
            check("abort_no_complete", c, int'(selectorComplete), 0);
            @(posedge clk);
            #1;
        end
        random_wave();
        run_scan(1'b0);

        // Back-to-back scans with random sensor activity
        for (int s = 0; s < 32; s++) begin
            random_wave();
            run_scan(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
